// File: rtl/psa_16bit_pkg.sv
// Shared lane geometry and saturation constants for the parallel sub-word adder.
package psa_16bit_pkg;

    localparam int unsigned LANE_W = 4;
    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = LANE_W * LANES;

    localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

    // On signed overflow both operand MSBs agree, so a_msb alone picks the clamp direction.
    function automatic logic [LANE_W-1:0] sat_lane(
        input logic [LANE_W-1:0] raw,
        input logic              ovfl,
        input logic              a_msb
    );
        if (!ovfl) begin
            return raw;
        end
        return a_msb ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/psa_16bit_cla_4bit.sv
// Combinational 4-bit carry-lookahead adder with group P/G and signed overflow.
module cla_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Ovfl,
    output logic       Pout,
    output logic       Gout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = A ^ B;
    assign g = A & B;

    // Every carry is flattened to two logic levels; no ripple between bits.
    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign Sum  = p ^ c[3:0];
    assign Pout = &p;
    assign Gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign Ovfl = c[3] ^ c[4];

endmodule

// File: rtl/psa_16bit.sv
// Registered four-lane signed 4-bit saturating adder (PADDSB) for the execute stage.
module psa_16bit
    import psa_16bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    output logic [DATA_W-1:0] Sum,
    output logic              Error
);

    logic [DATA_W-1:0] raw_sum;
    logic [DATA_W-1:0] sat_sum;
    logic [LANES-1:0]  lane_ovfl;
    logic [LANES-1:0]  lane_p_unused;
    logic [LANES-1:0]  lane_g_unused;

    logic [DATA_W-1:0] sum_q,   sum_d;
    logic              error_q, error_d;
    logic              valid_q, valid_d;

    // Lanes are fully independent: each CLA gets Cin=0 and its carry-out is dropped.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cla_4bit u_cla (
            .A    (A[i*LANE_W +: LANE_W]),
            .B    (B[i*LANE_W +: LANE_W]),
            .Cin  (1'b0),
            .Sum  (raw_sum[i*LANE_W +: LANE_W]),
            .Ovfl (lane_ovfl[i]),
            .Pout (lane_p_unused[i]),
            .Gout (lane_g_unused[i])
        );

        assign sat_sum[i*LANE_W +: LANE_W] = sat_lane(raw_sum[i*LANE_W +: LANE_W],
                                                      lane_ovfl[i],
                                                      A[i*LANE_W + LANE_W - 1]);
    end

    always_comb begin
        sum_d   = sum_q;
        error_d = error_q;
        valid_d = in_valid;
        if (in_valid) begin
            sum_d   = sat_sum;
            error_d = |lane_ovfl;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q   <= '0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
            valid_q <= valid_d;
        end
    end

    assign Sum       = sum_q;
    assign Error     = error_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_psa_16bit.sv
// Directed self-checking bench for psa_16bit and a standalone cla_4bit.
module tb_psa_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic [15:0] Sum;
    logic        Error;

    logic [3:0]  ca;
    logic [3:0]  cb;
    logic        ccin;
    logic [3:0]  csum;
    logic        covfl;
    logic        cpout;
    logic        cgout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    psa_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .Sum       (Sum),
        .Error     (Error)
    );

    cla_4bit u_cla (
        .A    (ca),
        .B    (cb),
        .Cin  (ccin),
        .Sum  (csum),
        .Ovfl (covfl),
        .Pout (cpout),
        .Gout (cgout)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] s, input logic e);
        check({tag, ".out_valid"}, 16'(out_valid), 16'(v));
        check({tag, ".Sum"},       Sum,            s);
        check({tag, ".Error"},     16'(Error),     16'(e));
    endtask

    // Drive on the falling edge, then look 1 time unit after the next rising edge.
    task automatic step(input logic rn, input logic v, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst_n    = rn;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 16'h0000;
        B        = 16'h0000;
        ca       = 4'b0000;
        cb       = 4'b0000;
        ccin     = 1'b0;

        step(1'b0, 1'b1, 16'hA5C3, 16'h7E19);
        step(1'b0, 1'b0, 16'h1F2E, 16'hFFFF);
        check_out("reset", 1'b0, 16'h0000, 1'b0);

        step(1'b1, 1'b1, 16'h10F7, 16'h1087);
        check_out("mixed_lanes", 1'b1, 16'h2087, 1'b1);

        step(1'b1, 1'b1, 16'h1234, 16'h1111);
        check_out("no_ovfl", 1'b1, 16'h2345, 1'b0);

        // -1+1 in lanes 0 and 2 wraps to 0 inside the lane; the carry-out must not leak upward.
        step(1'b1, 1'b1, 16'h0F0F, 16'h0101);
        check_out("lane_isolation", 1'b1, 16'h0000, 1'b0);

        step(1'b1, 1'b1, 16'hFFFF, 16'h8888);
        check_out("neg_sat_all", 1'b1, 16'h8888, 1'b1);

        step(1'b1, 1'b1, 16'h8765, 16'h7000);
        check_out("mixed_sign", 1'b1, 16'hF765, 1'b0);

        step(1'b1, 1'b1, 16'h7777, 16'h1111);
        check_out("stream0", 1'b1, 16'h7777, 1'b1);
        step(1'b1, 1'b1, 16'h8888, 16'h8888);
        check_out("stream1", 1'b1, 16'h8888, 1'b1);
        step(1'b1, 1'b1, 16'h3210, 16'h4321);
        check_out("stream2", 1'b1, 16'h7531, 1'b0);

        step(1'b1, 1'b0, 16'h7777, 16'h7777);
        check_out("hold0", 1'b0, 16'h7531, 1'b0);
        step(1'b1, 1'b0, 16'hFFFF, 16'h8888);
        check_out("hold1", 1'b0, 16'h7531, 1'b0);

        step(1'b1, 1'b1, 16'h7777, 16'h7777);
        check_out("pre_reset", 1'b1, 16'h7777, 1'b1);
        step(1'b0, 1'b1, 16'h1234, 16'h1111);
        check_out("reset_priority", 1'b0, 16'h0000, 1'b0);

        step(1'b1, 1'b1, 16'h1234, 16'h1111);
        check_out("post_reset", 1'b1, 16'h2345, 1'b0);

        ca = 4'b0001; cb = 4'b0001; ccin = 1'b0;
        #1;
        check("cla_1p1.Sum",  16'(csum),  16'h0002);
        check("cla_1p1.Ovfl", 16'(covfl), 16'h0000);
        check("cla_1p1.Gout", 16'(cgout), 16'h0000);
        check("cla_1p1.Pout", 16'(cpout), 16'h0000);

        ca = 4'b0111; cb = 4'b0001;
        #1;
        check("cla_7p1.Sum",  16'(csum),  16'h0008);
        check("cla_7p1.Ovfl", 16'(covfl), 16'h0001);

        ca = 4'b1010; cb = 4'b0101; ccin = 1'b1;
        #1;
        check("cla_prop.Sum",  16'(csum),  16'h0000);
        check("cla_prop.Pout", 16'(cpout), 16'h0001);
        check("cla_prop.Gout", 16'(cgout), 16'h0000);
        check("cla_prop.Ovfl", 16'(covfl), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
